// File: rtl/p448_pkg.sv
// p448_pkg: shared constants, state codes and limb storage types for the p448 carry chain.
package p448_pkg;
    localparam int NLIMBS      = 16;
    localparam int LIMB_BITS   = 28;
    localparam int WRAP_IDX    = 8;
    localparam int CARRY_WIDTH = 37;
    localparam int COL_WIDTH   = 64;
    localparam int OUT_WIDTH   = 32;
    localparam int ACC_WIDTH   = CARRY_WIDTH + 1;
    localparam int CNT_WIDTH   = $clog2(NLIMBS);

    typedef logic [1:0] state_t;
    localparam state_t ACCUM = 2'd0;
    localparam state_t WRAP  = 2'd1;
    localparam state_t FIX   = 2'd2;
    localparam state_t EMIT  = 2'd3;

    // limbs 0 and WRAP_IDX transiently hold a 38-bit sum between WRAP and FIX
    typedef logic [ACC_WIDTH-1:0] limb_t;
    typedef limb_t [NLIMBS-1:0] limb_arr_t;
endpackage

// File: rtl/p448_carry_step.sv
// p448_carry_step: one radix-2^28 carry step, splitting col+carry_in into a limb and the carry out.
module p448_carry_step
    import p448_pkg::*;
(
    input  logic [COL_WIDTH-1:0]   col,
    input  logic [CARRY_WIDTH-1:0] carry_in,
    output logic [LIMB_BITS-1:0]   limb,
    output logic [CARRY_WIDTH-1:0] carry_out
);
    logic [COL_WIDTH:0] t;

    assign t         = {1'b0, col} + {{(COL_WIDTH + 1 - CARRY_WIDTH){1'b0}}, carry_in};
    assign limb      = t[LIMB_BITS-1:0];
    assign carry_out = t[COL_WIDTH:LIMB_BITS];
endmodule

// File: rtl/p448_carry_chain.sv
// p448_carry_chain: serial carry propagation of 16 column sums into 28-bit limbs,
// folding the top carry via 2^448 = 2^224 + 1 and streaming out loosely-reduced limbs.
module p448_carry_chain
    import p448_pkg::*;
(
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [COL_WIDTH-1:0] in_col,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_limb,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 err
);
    state_t                 state;
    logic [CNT_WIDTH-1:0]   count;
    logic [CARRY_WIDTH-1:0] carry;
    limb_arr_t              limb;
    logic                   last, fix;
    logic [COL_WIDTH-1:0]   a_col;
    logic [CARRY_WIDTH-1:0] a_carry_in, a_carry, b_carry;
    logic [LIMB_BITS-1:0]   a_limb, b_limb;

    assign last = count == CNT_WIDTH'(NLIMBS - 1);
    assign fix  = state == FIX;

    // step a serves the column accumulation and, during FIX, renormalises limb 0
    assign a_col      = fix ? COL_WIDTH'(limb[0]) : in_col;
    assign a_carry_in = fix ? '0 : carry;

    p448_carry_step u_step_a (
        .col       (a_col),
        .carry_in  (a_carry_in),
        .limb      (a_limb),
        .carry_out (a_carry)
    );

    p448_carry_step u_step_b (
        .col       (COL_WIDTH'(limb[WRAP_IDX])),
        .carry_in  ('0),
        .limb      (b_limb),
        .carry_out (b_carry)
    );

    always_ff @(posedge ap_clk or posedge ap_rst)
        if (ap_rst) begin
            state <= ACCUM;
            count <= '0;
            carry <= '0;
            limb  <= '0;
            err   <= 1'b0;
        end else case (state)
            ACCUM: if (in_valid) begin
                limb[count] <= limb_t'(a_limb);
                carry       <= a_carry;
                count       <= last ? '0 : count + 1'b1;
                if (in_last != last) err <= 1'b1;
                if (last) state <= WRAP;
            end
            WRAP: begin
                limb[0]        <= limb[0] + limb_t'(carry);
                limb[WRAP_IDX] <= limb[WRAP_IDX] + limb_t'(carry);
                carry          <= '0;
                state          <= FIX;
            end
            FIX: begin
                limb[0]            <= limb_t'(a_limb);
                limb[WRAP_IDX]     <= limb_t'(b_limb);
                limb[1]            <= limb[1] + limb_t'(a_carry);
                limb[WRAP_IDX + 1] <= limb[WRAP_IDX + 1] + limb_t'(b_carry);
                state              <= EMIT;
            end
            default: if (out_ready) begin
                count <= last ? '0 : count + 1'b1;
                if (last) state <= ACCUM;
            end
        endcase

    assign in_ready  = state == ACCUM;
    assign out_valid = state == EMIT;
    assign out_last  = out_valid && last;
    assign out_limb  = out_valid ? limb[count][OUT_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_p448_carry_chain.sv
// tb_p448_carry_chain: randomized and directed frames checked against an arithmetic carry/fold model.
module tb_p448_carry_chain;
    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [63:0] in_col = '0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, out_last, err;
    logic [31:0] out_limb;
    int          n_chk = 0, n_pass = 0, beats = 0;
    logic [63:0] cols [16];
    logic [31:0] exp_l [16];

    p448_carry_chain dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_col    (in_col),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_limb  (out_limb),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) if (out_valid && out_ready) beats++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // value-level model: full-width carry ripple, fold c*2^448 into c + c*2^224, one renormalising step
    task automatic model();
        logic [127:0] l [16];
        logic [127:0] t, c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            t    = 128'(cols[i]) + c;
            l[i] = t % (128'd1 << 28);
            c    = t / (128'd1 << 28);
        end
        l[0] = l[0] + c;
        l[8] = l[8] + c;
        l[1] = l[1] + l[0] / (128'd1 << 28);
        l[0] = l[0] % (128'd1 << 28);
        l[9] = l[9] + l[8] / (128'd1 << 28);
        l[8] = l[8] % (128'd1 << 28);
        for (int i = 0; i < 16; i++) exp_l[i] = l[i][31:0];
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 16; i++) begin
            cols[i]  = '0;
            exp_l[i] = '0;
        end
    endtask

    task automatic send(input int bad_idx, input int max_gap);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(negedge ap_clk);
                in_valid = 1'b0;
            end
            @(negedge ap_clk);
            in_valid = 1'b1;
            in_col   = cols[i];
            in_last  = (bad_idx < 0) ? (i == 15) : (i == bad_idx);
            chk("in_ready_accum", in_ready, 1);
            @(posedge ap_clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic collect(input int stall_beat, input int stall_len, input int rst_beat);
        int w, b0;
        b0 = beats;
        w  = 0;
        while (!out_valid && w < 20) begin
            @(negedge ap_clk);
            w++;
        end
        chk("latency", w, 3);
        if (w >= 20) return;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge ap_clk);
            if (j == rst_beat) begin
                ap_rst = 1'b1;
                #1;
                chk("rst_out_valid", out_valid, 0);
                chk("rst_err", err, 0);
                chk("rst_in_ready", in_ready, 1);
                @(negedge ap_clk);
                ap_rst = 1'b0;
                @(negedge ap_clk);
                chk("rst_no_beats", beats - b0, j);
                return;
            end
            chk("out_valid", out_valid, 1);
            chk($sformatf("limb%0d", j), out_limb, exp_l[j]);
            chk("out_last", out_last, j == 15);
            chk("in_ready_emit", in_ready, 0);
            chk("limb_lt_2p29", out_limb < 32'h2000_0000, 1);
            if (j == stall_beat) begin
                out_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge ap_clk);
                    chk("stall_valid", out_valid, 1);
                    chk("stall_limb", out_limb, exp_l[j]);
                    chk("stall_last", out_last, j == 15);
                    chk("stall_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
            @(posedge ap_clk);
        end
        @(negedge ap_clk);
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("beats", beats - b0, 16);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_limb", out_limb, 0);
        chk("rst_err", err, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        clear_frame();
        send(-1, 0);
        collect(-1, 0, -1);
        chk("err_zero_frame", err, 0);

        clear_frame();
        cols[0]  = 64'h1FFF_FFFF;
        cols[1]  = 64'h0FFF_FFFF;
        exp_l[0] = 32'h0FFF_FFFF;
        exp_l[2] = 32'h1;
        send(-1, 1);
        collect(-1, 0, -1);

        clear_frame();
        cols[15] = 64'h1000_0000;
        exp_l[0] = 32'h1;
        exp_l[8] = 32'h1;
        send(-1, 0);
        collect(-1, 0, -1);

        for (int i = 0; i < 16; i++) cols[i] = '1;
        model();
        send(-1, 3);
        collect(-1, 0, -1);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) cols[i] = {$urandom, $urandom};
            model();
            send(-1, 2);
            collect(f == 1 ? 7 : -1, 5, -1);
        end
        chk("err_clean_frames", err, 0);

        for (int i = 0; i < 16; i++) cols[i] = {$urandom, $urandom};
        model();
        send(9, 1);
        collect(-1, 0, -1);
        chk("err_set", err, 1);

        for (int i = 0; i < 16; i++) cols[i] = {$urandom, $urandom};
        model();
        send(-1, 0);
        chk("err_sticky", err, 1);
        collect(-1, 0, 4);

        clear_frame();
        send(-1, 0);
        collect(-1, 0, -1);
        chk("err_after_rst", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/p448_carry_chain.md
Name: p448_carry_chain

Overview:
- Downstream consumer of the 32x33->64 limb-product multipliers in the p448 carry_mul datapath.
- Takes the 16 unsigned 64-bit column sums, one column per beat, and performs fiat-style carry propagation into 28-bit limbs.
- Folds the top carry back using 2^448 = 2^224 + 1 (mod p448) and streams out 16 loosely-reduced 32-bit limbs.
- Frame-serial: one field element in flight at a time.

Parameters:
- NLIMBS, 16, limbs per element (fixed for p448 32-bit representation)
- LIMB_BITS, 28, radix bits per limb
- COL_WIDTH, 64, input column-sum width
- OUT_WIDTH, 32, output limb word width
- WRAP_IDX, 8, limb receiving the 2^224 fold (WRAP_IDX*LIMB_BITS = 224)

Ports:
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst  in  1  asynchronous active-high reset
- in_col  in  COL_WIDTH  column sum i, limb order 0..15
- in_valid  in  1  in_col valid
- in_last  in  1  marks column 15
- in_ready  out  1  block accepts column
- out_limb  out  OUT_WIDTH  reduced limb j, order 0..15
- out_valid  out  1  out_limb valid
- out_last  out  1  marks limb 15
- out_ready  in  1  downstream accepts limb
- err  out  1  sticky in_last framing error

Behaviour:
- Reset values (asynchronous on ap_rst):
  - state=ACCUM, count=0, carry=0, limb array=0
  - in_ready=1, out_valid=0, out_last=0, out_limb=0, err=0
- State ACCUM: in_ready=1.
  - On in_valid&in_ready: t = in_col + carry, 65-bit unsigned, no truncation.
  - limb[count] = t[27:0]; carry = t>>28, 37 bits.
  - count increments; after column 15, go to WRAP and clear count.
- WRAP, 1 cycle:
  - limb[0] += carry and limb[8] += carry, each a 38-bit sum.
  - carry cleared.
- FIX, 1 cycle:
  - c0 = limb[0]>>28 and c8 = limb[8]>>28.
  - limb[0] and limb[8] keep their low 28 bits.
  - limb[1] += c0 and limb[9] += c8.
  - limb[1] and limb[9] may exceed 28 bits (< 2^29); all limbs fit OUT_WIDTH.
- EMIT: out_valid=1, out_limb=limb[count].
  - out_last=1 when count=15.
  - Advance only on out_valid&out_ready.
  - out_limb, out_last and out_valid are held stable while out_ready=0.
  - After beat 15 is accepted: return to ACCUM, count=0, in_ready=1 next cycle.
- Latency: column 15 accepted at edge T; WRAP at T+1, FIX at T+2, out_valid high from T+3. Throughput is one frame per 16+2+16 cycles minimum.
- in_ready=0 in WRAP, FIX and EMIT; input is not accepted during output.
- Framing:
  - The column count is authoritative.
  - in_last=1 with count!=15, or in_last=0 with count=15, sets err (sticky until ap_rst). Processing continues by count.
- in_valid=0 gaps in ACCUM are allowed; state is held.
- Reset mid-frame in any state: the partial frame is discarded, no out_valid beat is produced, and the first frame after release is processed correctly.
- Arithmetic is unsigned only; no signed interpretation of columns.

Decomposition:
- Shared package p448_pkg:
  - NLIMBS, LIMB_BITS, WRAP_IDX, CARRY_WIDTH=37
  - state enum {ACCUM, WRAP, FIX, EMIT}
  - limb array typedef
- One natural sub-module, p448_carry_step (combinational): (col, carry_in) -> (limb, carry_out). It is shared by the ACCUM datapath and the FIX propagation.
- FSM, counters and limb register array live in the top module.

Test Plan:
- All 16 columns 0, out_ready=1 -> 16 limbs of 0; out_last only on beat 16; err=0; out_valid rises 3 cycles after column 15 is accepted.
- col0=0x1FFFFFFF, col1=0x0FFFFFFF, rest 0 -> limb0=0x0FFFFFFF, limb1=0, limb2=1, others 0.
- col15=0x10000000, rest 0 -> carry 1 folds -> limb0=1, limb8=1, limb15=0, others 0.
- All columns 0xFFFFFFFFFFFFFFFF with random in_valid gaps -> output matches the bit-exact software carry model; every limb < 2^29.
- out_ready held low 5 cycles at beat 7 -> out_limb and out_last stable and beat 7 repeated; in_ready=0 throughout; exactly 16 beats delivered.
- in_last asserted on column 9 -> err=1 sticky and output still correct for 16 columns. Then ap_rst pulsed mid-EMIT -> out_valid=0 and err=0 immediately; the next zero frame yields 16 zeros.
